// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage with one outstanding imem request and a 2-entry output FIFO
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q;
  logic [31:0] pc_q [2];
  logic [31:0] ins_q [2];
  logic [31:0] pc_d [2];
  logic [31:0] ins_d [2];
  logic [1:0]  cnt_q, cnt_d, cnt_pop, occ;
  logic        pop, push, accept, unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign if_valid = cnt_q != 2'd0;
  assign pop = if_valid & ~stall & ~redirect;
  assign push = (state_q == WAIT) & imem_rsp_valid & ~redirect;
  assign cnt_pop = cnt_q - {1'b0, pop};
  assign occ = cnt_pop + {1'b0, push};
  // Requests only go out when the FIFO is guaranteed room for their response
  assign imem_req_valid = ~reset & ~redirect & (state_q != DROP) &
                          ((state_q == IDLE) | imem_rsp_valid) & (occ <= 2'd1);
  assign imem_req_addr = fetch_pc_q;
  assign accept = imem_req_valid & imem_req_ready;
  assign if_pc = if_valid ? pc_q[0] : '0;
  assign if_instruction = if_valid ? ins_q[0] : NOP_INSTR;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? WAIT : IDLE;
      WAIT:    state_d = imem_rsp_valid ? (accept ? WAIT : IDLE) : (redirect ? DROP : WAIT);
      DROP:    state_d = imem_rsp_valid ? IDLE : DROP;
      default: state_d = IDLE;
    endcase
    fetch_pc_d = redirect ? {redirect_pc[31:2], 2'b00} : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    pc_d[0] = (push & (cnt_pop == 2'd0)) ? req_pc_q : pop ? pc_q[1] : pc_q[0];
    ins_d[0] = (push & (cnt_pop == 2'd0)) ? imem_rsp_data : pop ? ins_q[1] : ins_q[0];
    pc_d[1] = (push & (cnt_pop == 2'd1)) ? req_pc_q : pc_q[1];
    ins_d[1] = (push & (cnt_pop == 2'd1)) ? imem_rsp_data : ins_q[1];
    cnt_d = redirect ? 2'd0 : occ;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      cnt_q <= cnt_d;
    end
    req_pc_q <= accept ? fetch_pc_q : req_pc_q;
    pc_q <= pc_d;
    ins_q <= ins_d;
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed vectors plus multi-cycle sequences against a latency-configurable memory model
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic [31:0] if_pc, if_instruction;
  int errors = 0;
  int checks = 0;
  int lat = 1;
  int left = 0;
  bit pend = 0;
  logic [31:0] paddr = '0;
  logic obs_req, obs_acc;
  logic [31:0] obs_addr;
  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl [12];

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: memory drives its response, request side is observed, then the edge
  task automatic tick();
    imem_rsp_valid = pend && left == 1;
    imem_rsp_data = imem_rsp_valid ? paddr ^ KEY : 32'h0;
    #1;
    obs_req = imem_req_valid;
    obs_addr = imem_req_addr;
    obs_acc = imem_req_valid & imem_req_ready;
    @(posedge clk);
    if (pend) begin
      if (imem_rsp_valid) pend = 0;
      else left--;
    end
    if (obs_acc) begin
      pend = 1;
      left = lat;
      paddr = obs_addr;
    end
    @(negedge clk);
  endtask

  task automatic chk_head(input string name, input logic v, input logic [31:0] pc);
    chk({name, "_valid"}, {31'b0, if_valid}, {31'b0, v});
    chk({name, "_pc"}, if_pc, v ? pc : 32'h0);
    chk({name, "_instr"}, if_instruction, v ? pc ^ KEY : NOP);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h4};
    tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h8};
    for (int i = 4; i < 9; i++) tbl[i] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h8};
    tbl[9]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'hC};
    tbl[10] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h10};
    tbl[11] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h14};
    @(negedge clk);
    tick();
    tick();
    chk("reset_req", {31'b0, obs_req}, 32'h0);
    chk_head("reset", 1'b0, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      stall = tbl[i].stall;
      tick();
      chk($sformatf("vec%0d_req", i), {31'b0, obs_req}, {31'b0, tbl[i].req});
      chk($sformatf("vec%0d_addr", i), obs_addr, tbl[i].addr);
      chk_head($sformatf("vec%0d", i), tbl[i].v, tbl[i].pc);
    end
    stall = 1'b0;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("noready%0d_req", i), {31'b0, obs_req}, 32'h1);
      chk($sformatf("noready%0d_addr", i), obs_addr, 32'h1C);
    end
    chk_head("noready_empty", 1'b0, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    chk("ready_acc", {31'b0, obs_acc}, 32'h1);
    chk("ready_addr", obs_addr, 32'h1C);
    tick();
    chk_head("ready_head", 1'b1, 32'h1C);

    lat = 3;
    reset = 1'b1;
    tick();
    tick();
    tick();
    tick();
    reset = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = obs_acc && obs_addr == 32'h10;
    end
    chk("wait_req10", {31'b0, found}, 32'h1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("redir_req", {31'b0, obs_req}, 32'h0);
    chk_head("redir_flush", 1'b0, 32'h0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = obs_acc;
      if (!found) chk($sformatf("redir_empty%0d", i), {31'b0, if_valid}, 32'h0);
    end
    chk("redir_acc", {31'b0, found}, 32'h1);
    chk("redir_addr", obs_addr, 32'h100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = if_valid;
    end
    chk_head("redir_head", 1'b1, 32'h100);

    lat = 1;
    reset = 1'b1;
    tick();
    tick();
    tick();
    tick();
    reset = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("full_req", {31'b0, obs_req}, 32'h0);
    chk_head("full_head", 1'b1, 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    chk("rs_req", {31'b0, obs_req}, 32'h0);
    redirect = 1'b0;
    stall = 1'b0;
    chk_head("rs_flush", 1'b0, 32'h0);
    tick();
    chk("rs_acc", {31'b0, obs_acc}, 32'h1);
    chk("rs_addr", obs_addr, 32'h200);
    tick();
    chk_head("rs_head", 1'b1, 32'h200);

    lat = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = obs_acc;
    end
    chk("rst_outstanding", {31'b0, found}, 32'h1);
    reset = 1'b1;
    tick();
    chk("rst_req", {31'b0, obs_req}, 32'h0);
    chk_head("rst_state", 1'b0, 32'h0);
    reset = 1'b0;
    tick();
    chk("rst_first_acc", {31'b0, obs_acc}, 32'h1);
    chk("rst_first_addr", obs_addr, 32'h0);
    chk_head("rst_stale", 1'b0, 32'h0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = if_valid;
    end
    chk_head("rst_head", 1'b1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
